core_frame_loader: RTL and testbench
====================================

// Module: core_frame_loader
// PURPOSE
//  Per-core receiver for the instruction-frame broadcast from the task scheduler.
//  - Captures the Insn_Data chunks addressed by Insn_Load_Counter while this core's Start bit is high.
//  - Assembles them into one full instruction frame, plus an optional R0 init value.
//  - Hands the frame to the core pipeline with a valid/ready handshake.
//  - Drives the core's Ready bit back to the scheduler. One instance per core.
// PARAMETERS
//  LOAD_TIME   4   chunks per frame (= scheduler INSN_LOAD_TIME)
//  CNT_W       2   width of the load counter, >= clog2(LOAD_TIME)
//  INSN_BUS_W  64  width of one Insn_Data chunk
//  REG_W       8   width of the R0 init value
// PORTS
//  clk            in   1                   system clock
//  reset          in   1                   asynchronous, active-low reset
//  start          in   1                   this core's bit of Start
//  load_cnt       in   CNT_W               Insn_Load_Counter
//  insn_data      in   INSN_BUS_W          Insn_Data chunk
//  init_r0_en     in   1                   this core's bit of Init_R0_Vect
//  init_r0        in   REG_W               this core's slice of Init_R0
//  ready          out  1                   to the scheduler Ready vector; 1 = idle / accepting a load
//  frame_valid    out  1                   complete frame offered to the core
//  frame_data     out  LOAD_TIME*INSN_BUS_W  chunk k sits at bits [k*INSN_BUS_W +: INSN_BUS_W]
//  frame_r0_we    out  1                   the core must load R0 from frame_r0 on handshake
//  frame_r0       out  REG_W               R0 init value
//  frame_ready    in   1                   core accepts the frame
//  core_done      in   1                   single-cycle pulse: core finished the frame
//  load_err       out  1                   sticky protocol error (CORE_FRAME_LOADER_CHECK_EN only)
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE, ready=1, frame_valid=0, frame_r0_we=0,
//    frame_data=0, frame_r0=0, load_err=0, expected index=0.
//  - FSM states: IDLE, LOAD, HANDOFF, EXEC. All outputs are registered.
//  - IDLE:
//    - On a posedge with start=1: write insn_data into chunk[load_cnt], then go to LOAD
//      (or straight to HANDOFF if load_cnt==LOAD_TIME-1).
//  - LOAD:
//    - Each posedge with start=1 writes chunk[load_cnt].
//    - start=0 is a scheduler stall: hold the partial frame and stay in LOAD.
//    - The write with load_cnt==LOAD_TIME-1 completes the frame. Go to HANDOFF and
//      sample init_r0_en/init_r0 into frame_r0_we/frame_r0 on the same edge.
//  - ready=1 throughout IDLE and LOAD. This is mandatory: the scheduler stalls the load
//    counter if Ready drops mid-load.
//  - ready=0 from the cycle after the last chunk (HANDOFF, EXEC) until back in IDLE.
//  - HANDOFF:
//    - frame_valid=1; frame_data, frame_r0 and frame_r0_we are held stable.
//    - A posedge with frame_ready=1 -> EXEC, with frame_valid=0 next cycle.
//  - EXEC:
//    - A core_done pulse -> IDLE, with ready=1 the next cycle.
//    - frame_data keeps its last value (not cleared).
//  - Latency:
//    - Last chunk edge T -> frame_valid=1 and ready=0 at T+1.
//    - core_done edge D -> ready=1 at D+1.
//  - Ignored inputs:
//    - core_done outside EXEC.
//    - frame_ready outside HANDOFF.
//    - start in HANDOFF/EXEC: no write; the buffer is unchanged.
//  - Simultaneous events:
//    - core_done and start on the same edge in EXEC: core_done wins, start is dropped.
//      The scheduler cannot do this legally, since ready was 0.
//  - load_cnt >= LOAD_TIME: no write.
//  - Reset mid-operation: the frame is discarded and all state returns to its reset values
//    immediately.
// CONFIGURATION
//  CORE_FRAME_LOADER_CHECK_EN defined:
//   - An expected-index register tracks the next chunk (0..LOAD_TIME-1) and returns to 0
//     on frame completion.
//   - load_err is set, sticky until reset, on any of:
//     - load_cnt != expected while start=1 in IDLE/LOAD;
//     - start=1 in HANDOFF/EXEC;
//     - load_cnt >= LOAD_TIME.
//   - A mismatching chunk is still written at load_cnt.
//  Undefined: no expected-index register, load_err is tied to 0, and chunks are written at
//  whatever load_cnt indicates.
// TESTING
//  T1 Reset: reset low, then released -> ready=1, frame_valid=0, load_err=0.
//  T2 Nominal load (LOAD_TIME=4):
//     - Stimulus: start=1 for 4 cycles, load_cnt=0..3, data A0..A3, init_r0_en=1, init_r0=8'h5A.
//     - Response: next cycle frame_valid=1, frame_data={A3,A2,A1,A0}, frame_r0_we=1,
//       frame_r0=8'h5A, ready=0; ready stays 1 during all 4 load cycles.
//  T3 Stall: start low for 3 cycles after chunk 1 (load_cnt held at 2) -> ready stays 1,
//     no writes during the stall, final frame identical to T2.
//  T4 Handoff/exec:
//     - Hold frame_ready=0 for 5 cycles -> frame_valid stays 1 and stable.
//     - frame_ready=1 -> EXEC.
//     - core_done pulse 10 cycles later -> ready=1 on the next cycle.
//     - A second load then overwrites with B0..B3 correctly.
//  T5 Illegal start: start=1 with load_cnt=0 during EXEC -> frame_data unchanged;
//     load_err=1 with CHECK_EN, 0 without it.
//  T6 Async reset mid-LOAD after 2 chunks -> outputs reset immediately without a clock edge;
//     a fresh 4-chunk load completes normally.

Source files
------------

// File: rtl/core_frame_loader.sv
// rtl/core_frame_loader.sv - per-core receiver that assembles broadcast instruction chunks into one frame
// Optional protocol checking (expected index, sticky load_err) under CORE_FRAME_LOADER_CHECK_EN.
module core_frame_loader #(
  parameter int LOAD_TIME  = 4,
  parameter int CNT_W      = 2,
  parameter int INSN_BUS_W = 64,
  parameter int REG_W      = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [CNT_W-1:0]                load_cnt_i,
  input  logic [INSN_BUS_W-1:0]           insn_data_i,
  input  logic                            init_r0_en_i,
  input  logic [REG_W-1:0]                init_r0_i,
  output logic                            ready_o,
  output logic                            frame_valid_o,
  output logic [LOAD_TIME*INSN_BUS_W-1:0] frame_data_o,
  output logic                            frame_r0_we_o,
  output logic [REG_W-1:0]                frame_r0_o,
  input  logic                            frame_ready_i,
  input  logic                            core_done_i,
  output logic                            load_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HANDOFF, S_EXEC} state_e;

  state_e                          state_q, state_d;
  logic                            ready_q, ready_d;
  logic                            valid_q, valid_d;
  logic [LOAD_TIME*INSN_BUS_W-1:0] frame_q, frame_d;
  logic                            r0_we_q, r0_we_d;
  logic [REG_W-1:0]                r0_q, r0_d;

  logic [31:0] cnt_ext;
  logic        cnt_ok, cnt_last, accepting, wr_en;

  assign cnt_ext   = 32'(load_cnt_i);
  assign cnt_ok    = cnt_ext < 32'(LOAD_TIME);
  assign cnt_last  = cnt_ext == 32'(LOAD_TIME - 1);
  assign accepting = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign wr_en     = accepting && start_i && cnt_ok;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    r0_we_d = r0_we_q;
    r0_d    = r0_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = cnt_last ? S_HANDOFF : S_LOAD;
      S_LOAD:    if (start_i && cnt_last) state_d = S_HANDOFF;
      S_HANDOFF: if (frame_ready_i) state_d = S_EXEC;
      S_EXEC:    if (core_done_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (wr_en) begin
      for (int k = 0; k < LOAD_TIME; k++) begin
        if (cnt_ext == 32'(k)) frame_d[k*INSN_BUS_W +: INSN_BUS_W] = insn_data_i;
      end
    end
    // R0 init travels with the chunk that completes the frame
    if (accepting && start_i && cnt_last) begin
      r0_we_d = init_r0_en_i;
      r0_d    = init_r0_i;
    end
    ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    valid_d = (state_d == S_HANDOFF);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      frame_q <= '0;
      r0_we_q <= 1'b0;
      r0_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      r0_we_q <= r0_we_d;
      r0_q    <= r0_d;
    end
  end

  assign ready_o       = ready_q;
  assign frame_valid_o = valid_q;
  assign frame_data_o  = frame_q;
  assign frame_r0_we_o = r0_we_q;
  assign frame_r0_o    = r0_q;

`ifdef CORE_FRAME_LOADER_CHECK_EN
  logic [CNT_W-1:0] exp_q, exp_d;
  logic             err_q, err_d;

  always_comb begin
    exp_d = exp_q;
    err_d = err_q;
    if (start_i) begin
      if (!accepting || !cnt_ok || (load_cnt_i != exp_q)) err_d = 1'b1;
      // resynchronise to the observed index so one slip reports once
      if (wr_en) exp_d = cnt_last ? '0 : CNT_W'(load_cnt_i + 1'b1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  assign load_err_o = err_q;
`else
  assign load_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_core_frame_loader.sv
// tb/tb_core_frame_loader.sv - randomized and directed bench for core_frame_loader against a behavioural model
module tb_core_frame_loader;
  localparam int LT = 4;
  localparam int CW = 2;
  localparam int W  = 64;
  localparam int RW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CW-1:0]     load_cnt = '0;
  logic [W-1:0]      insn_data = '0;
  logic              init_r0_en = 1'b0;
  logic [RW-1:0]     init_r0 = '0;
  logic              ready, frame_valid, frame_r0_we, load_err;
  logic [LT*W-1:0]   frame_data;
  logic [RW-1:0]     frame_r0;
  logic              frame_ready = 1'b0;
  logic              core_done = 1'b0;

  core_frame_loader #(.LOAD_TIME(LT), .CNT_W(CW), .INSN_BUS_W(W), .REG_W(RW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .load_cnt_i(load_cnt),
    .insn_data_i(insn_data), .init_r0_en_i(init_r0_en), .init_r0_i(init_r0),
    .ready_o(ready), .frame_valid_o(frame_valid), .frame_data_o(frame_data),
    .frame_r0_we_o(frame_r0_we), .frame_r0_o(frame_r0), .frame_ready_i(frame_ready),
    .core_done_i(core_done), .load_err_o(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [LT*W-1:0] act, input logic [LT*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 = accepting chunks, 1 = frame offered, 2 = core executing
  int           m_mode;
  logic [W-1:0] m_buf [LT];
  logic         m_we;
  logic [RW-1:0] m_r0;
  logic         m_err;
  int           m_exp;

  function automatic logic [LT*W-1:0] m_frame();
    logic [LT*W-1:0] f;
    for (int k = 0; k < LT; k++) f[k*W +: W] = m_buf[k];
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      for (int k = 0; k < LT; k++) m_buf[k] = '0;
      m_we = 1'b0; m_r0 = '0; m_err = 1'b0; m_exp = 0;
    end else begin
      int c;
      c = int'(load_cnt);
      if (start && (m_mode != 0 || c >= LT || c != m_exp)) m_err = 1'b1;
      case (m_mode)
        0: if (start && c < LT) begin
             m_buf[c] = insn_data;
             m_exp = (c == LT - 1) ? 0 : c + 1;
             if (c == LT - 1) begin
               m_we = init_r0_en; m_r0 = init_r0; m_mode = 1;
             end
           end
        1: if (frame_ready) m_mode = 2;
        default: if (core_done) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", ready, m_mode == 0);
      chk("frame_valid", frame_valid, m_mode == 1);
      chk("frame_data", frame_data, m_frame());
      chk("frame_r0_we", frame_r0_we, m_we);
      chk("frame_r0", frame_r0, m_r0);
`ifdef CORE_FRAME_LOADER_CHECK_EN
      chk("load_err", load_err, m_err);
`else
      chk("load_err", load_err, 1'b0);
`endif
    end
  end

  task automatic load_frame(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3,
                            input int stall_after, input int stall_len,
                            input logic en, input logic [RW-1:0] r0);
    logic [W-1:0] d [LT];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    init_r0_en = en; init_r0 = r0;
    for (int k = 0; k < LT; k++) begin
      @(negedge clk);
      start = 1'b1; load_cnt = CW'(k); insn_data = d[k];
      if (k == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("ready_during_load", ready, 1'b1);
          start = 1'b0; load_cnt = CW'(k + 1); insn_data = ~d[k];
        end
      end
    end
    @(negedge clk);
    start = 1'b0; insn_data = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  localparam logic [W-1:0] A0 = 64'h0000_0000_0000_00A0, A1 = 64'h1111_1111_1111_11A1;
  localparam logic [W-1:0] A2 = 64'h2222_2222_2222_22A2, A3 = 64'h3333_3333_3333_33A3;
  localparam logic [W-1:0] B0 = 64'hB0B0_0000_DEAD_0000, B1 = 64'hB1B1_1111_DEAD_0001;
  localparam logic [W-1:0] B2 = 64'hB2B2_2222_DEAD_0002, B3 = 64'hB3B3_3333_DEAD_0003;
  localparam logic [LT*W-1:0] FRAME_A = {A3, A2, A1, A0};
  localparam logic [LT*W-1:0] FRAME_B = {B3, B2, B1, B0};

  initial begin
    // T1 reset
    idle(3);
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_data", frame_data, '0);
    chk("rst_err", load_err, 1'b0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(2);

    // T2 nominal load
    load_frame(A0, A1, A2, A3, -1, 0, 1'b1, 8'h5A);
    chk("t2_valid", frame_valid, 1'b1);
    chk("t2_ready", ready, 1'b0);
    chk("t2_data", frame_data, FRAME_A);
    chk("t2_r0_we", frame_r0_we, 1'b1);
    chk("t2_r0", frame_r0, 8'h5A);

    // T4 hold off handshake, then accept and execute
    idle(5);
    chk("t4_hold_valid", frame_valid, 1'b1);
    chk("t4_hold_data", frame_data, FRAME_A);
    frame_ready = 1'b1; idle(1); frame_ready = 1'b0;
    chk("t4_exec_valid", frame_valid, 1'b0);
    idle(10);
    core_done = 1'b1; idle(1); core_done = 1'b0;
    chk("t4_done_ready", ready, 1'b1);

    // T3 stall after chunk 1, same frame as T2 expected
    load_frame(A0, A1, A2, A3, 1, 3, 1'b1, 8'h5A);
    chk("t3_data", frame_data, FRAME_A);
    chk("t3_r0", frame_r0, 8'h5A);
    frame_ready = 1'b1; idle(1); frame_ready = 1'b0;
    idle(3);
    core_done = 1'b1; idle(1); core_done = 1'b0;

    // second load overwrites, then illegal start during exec (T5)
    load_frame(B0, B1, B2, B3, -1, 0, 1'b0, 8'h33);
    chk("t4_b_data", frame_data, FRAME_B);
    chk("t4_b_r0_we", frame_r0_we, 1'b0);
    frame_ready = 1'b1; idle(1); frame_ready = 1'b0;
    start = 1'b1; load_cnt = '0; insn_data = 64'hFFFF_FFFF_FFFF_FFFF;
    idle(1); start = 1'b0;
    idle(1);
    chk("t5_data", frame_data, FRAME_B);
`ifdef CORE_FRAME_LOADER_CHECK_EN
    chk("t5_err", load_err, 1'b1);
`else
    chk("t5_err", load_err, 1'b0);
`endif
    core_done = 1'b1; idle(1); core_done = 1'b0;

    // T6 async reset after two chunks
    init_r0_en = 1'b1; init_r0 = 8'h77;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; load_cnt = CW'(k); insn_data = 64'hC0 + 64'(k);
    end
    @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ready", ready, 1'b1);
    chk("t6_valid", frame_valid, 1'b0);
    chk("t6_data", frame_data, '0);
    chk("t6_r0", frame_r0, '0);
    chk("t6_err", load_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    load_frame(B0, B1, B2, B3, 2, 1, 1'b1, 8'hC3);
    chk("t6_data_after", frame_data, FRAME_B);
    chk("t6_r0_after", frame_r0, 8'hC3);
    frame_ready = 1'b1; idle(1); frame_ready = 1'b0;
    core_done = 1'b1; idle(1); core_done = 1'b0;

    // randomized traffic, including out-of-order indices and spurious handshakes
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start       = ($urandom_range(0, 9) < 6);
      load_cnt    = CW'($urandom_range(0, LT - 1));
      insn_data   = {$urandom, $urandom};
      init_r0_en  = 1'($urandom_range(0, 1));
      init_r0     = RW'($urandom);
      frame_ready = ($urandom_range(0, 3) == 0);
      core_done   = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    start = 1'b0; frame_ready = 1'b0; core_done = 1'b0;
    idle(2);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
